uart_rx_ctrl: RTL and testbench

- 8250-style receive controller that sequences 8-bit asynchronous serial reception and presents bytes to a host.
- Generates the 16x oversample enable from a programmable divisor and validates the start bit with mid-bit sampling.
- Buffers received bytes in a small FIFO and maintains line-status flags (data ready, overrun, framing error) plus an interrupt.
- Sits between the serial input pin and the host bus decode logic.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_fifo.sv | 44 ++++
 rtl/uart_rx_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the 8250-style receive path: FSM states and
// oversampling constants.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int BIT_SAMPLE = 15;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO. A pop on a full FIFO frees the slot for a push in the
// same cycle; pops on empty and pushes on full (without pop) are dropped.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Storage and pointer update; storage is cleared so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8250-style receive controller: synchronizer, 16x baud tick, start-bit
// validation, byte assembly, receive FIFO and line-status flags.
// Optional even-parity check enabled by defining UART_RX_PARITY_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] divisor,
  input  logic             serial_in,
  input  logic             rd_en,
  input  logic             lsr_rd,
  input  logic             irq_en,
  output logic [7:0]       rx_data,
  output logic             data_ready,
  output logic             overrun_err,
  output logic             frame_err,
  output logic             irq
`ifdef UART_RX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);

  logic             rx_s1, rx_s;
  logic [DIV_W-1:0] div_cnt, div_lat;
  logic             tick;
  rx_state_e        state, state_nxt;
  logic [SUB_W-1:0] sub_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [7:0]       shreg;
  logic             mid_pt, bit_pt, last_bit;
  logic             sub_clr, bit_clr, shift_en, stop_smp;
  logic             push_q, stop_bad_q;
  logic             fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic             par_smp, par_bad, par_bad_q;
`endif

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_s1 <= serial_in;
      rx_s  <= rx_s1;
    end
  end

  // Divisor is latched at each wrap so a new value only takes effect then.
  assign tick = (div_lat <= DIV_W'(1)) || (div_cnt == div_lat - DIV_W'(1));

  // 16x oversample tick generator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      div_lat <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      div_lat <= divisor;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign mid_pt   = (sub_cnt == SUB_W'(MID_SAMPLE));
  assign bit_pt   = (sub_cnt == SUB_W'(BIT_SAMPLE));
  assign last_bit = (bit_cnt == BIT_W'(DATA_BITS - 1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; all transitions happen on a baud tick.
  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        IDLE:   if (!rx_s) state_nxt = START;
        START:  if (mid_pt) state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
        DATA:   if (bit_pt && last_bit) state_nxt = PARITY;
        PARITY: if (bit_pt) state_nxt = STOP;
`else
        DATA:   if (bit_pt && last_bit) state_nxt = STOP;
`endif
        STOP:   if (bit_pt) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs: sample strobes and counter controls.
  always_comb begin
    sub_clr  = 1'b0;
    bit_clr  = 1'b0;
    shift_en = 1'b0;
    stop_smp = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_smp  = 1'b0;
`endif
    if (tick) begin
      case (state)
        IDLE:  sub_clr = 1'b1;
        START: begin
          sub_clr = mid_pt;
          bit_clr = mid_pt;
        end
        DATA: begin
          sub_clr  = bit_pt;
          shift_en = bit_pt;
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          sub_clr = bit_pt;
          par_smp = bit_pt;
        end
`endif
        STOP: begin
          sub_clr  = bit_pt;
          stop_smp = bit_pt;
        end
        default: sub_clr = 1'b1;
      endcase
    end
  end

  // Oversample/bit counters and LSB-first shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (tick)         sub_cnt <= sub_clr ? '0 : sub_cnt + 1'b1;
      if (bit_clr)      bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
      if (shift_en)     shreg   <= {rx_s, shreg[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: data ones plus parity bit must be even.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       par_bad <= 1'b0;
    else if (par_smp) par_bad <= rx_s ^ (^shreg);
  end
`endif

  // Push strobe one cycle after the stop sample, with its error qualifiers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_q     <= 1'b0;
      stop_bad_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= 1'b0;
`endif
    end else begin
      push_q     <= stop_smp;
      stop_bad_q <= stop_smp & ~rx_s;
`ifdef UART_RX_PARITY_EN
      par_bad_q  <= stop_smp & par_bad;
`endif
    end
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_q),
    .pop   (rd_en),
    .wdata (shreg),
    .rdata (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign data_ready = ~fifo_empty;

  // Sticky line-status flags; a new error wins over a status-read clear.
  // A pop in the push cycle makes room, so full only overruns without rd_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_err <= 1'b0;
      frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      if (push_q && fifo_full && !rd_en) overrun_err <= 1'b1;
      else if (lsr_rd)                   overrun_err <= 1'b0;
      if (push_q && stop_bad_q)          frame_err   <= 1'b1;
      else if (lsr_rd)                   frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      if (push_q && par_bad_q)           parity_err  <= 1'b1;
      else if (lsr_rd)                   parity_err  <= 1'b0;
`endif
    end
  end

  // Registered receive interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= data_ready & irq_en;
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: table of single-byte frames plus
// hand-written sequences for latency, false start, overrun, pop-on-full
// and reset mid-frame.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] divisor;
  logic        serial_in, rd_en, lsr_rd, irq_en;
  logic [7:0]  rx_data;
  logic        data_ready, overrun_err, frame_err, irq;
`ifdef UART_RX_PARITY_EN
  logic        parity_err;
  logic        tx_par_flip = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .divisor     (divisor),
    .serial_in   (serial_in),
    .rd_en       (rd_en),
    .lsr_rd      (lsr_rd),
    .irq_en      (irq_en),
    .rx_data     (rx_data),
    .data_ready  (data_ready),
    .overrun_err (overrun_err),
    .frame_err   (frame_err),
    .irq         (irq)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_fe;
  } vec_t;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
  endtask

  task automatic lsr_read();
    lsr_rd = 1'b1;
    step(1);
    lsr_rd = 1'b0;
  endtask

  // One frame, LSB first. A low stop bit is released after 3/4 of a bit so
  // the trailing low time is rejected as a false start.
  task automatic send_byte(input logic [7:0] d, input logic stop);
    int bc;
    bc = 16 * ((divisor < 16'd2) ? 1 : int'(divisor));
    serial_in = 1'b0;
    step(bc);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      step(bc);
    end
`ifdef UART_RX_PARITY_EN
    serial_in = (^d) ^ tx_par_flip;
    step(bc);
`endif
    if (stop) begin
      serial_in = 1'b1;
      step(bc);
    end else begin
      serial_in = 1'b0;
      step(bc * 3 / 4);
      serial_in = 1'b1;
      step(bc / 4);
    end
    serial_in = 1'b1;
    step(bc / 2);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   n;
`ifdef UART_RX_PARITY_EN
    int   push_wait = 171;
`else
    int   push_wait = 155;
`endif
    vecs[0] = '{data: 8'h3C, stop: 1'b0, exp_data: 8'h3C, exp_fe: 1'b1};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_fe: 1'b0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_data: 8'hFF, exp_fe: 1'b0};
    vecs[3] = '{data: 8'h81, stop: 1'b0, exp_data: 8'h81, exp_fe: 1'b1};

    divisor   = 16'd4;
    serial_in = 1'b1;
    rd_en     = 1'b0;
    lsr_rd    = 1'b0;
    irq_en    = 1'b1;

    // Reset state.
    step(3);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_overrun", overrun_err, 0);
    chk("rst_frame", frame_err, 0);
    chk("rst_irq", irq, 0);
    rst_n = 1'b1;
    step(10);

    // Basic receive with irq following data_ready by one cycle.
    fork
      send_byte(8'hA5, 1'b1);
      begin
        n = 0;
        while (!data_ready && n < 2000) begin
          step(1);
          n++;
        end
        chk("basic_dr_rise", data_ready, 1);
        chk("basic_irq_lag0", irq, 0);
        step(1);
        chk("basic_irq_lag1", irq, 1);
      end
    join
    chk("basic_rx_data", rx_data, 8'hA5);
    pop();
    chk("basic_pop_dr", data_ready, 0);
    chk("basic_irq_hold", irq, 1);
    step(1);
    chk("basic_irq_fall", irq, 0);

    // False start: 5 ticks low.
    serial_in = 1'b0;
    step(20);
    serial_in = 1'b1;
    step(200);
    chk("false_dr", data_ready, 0);
    chk("false_fe", frame_err, 0);
    chk("false_ov", overrun_err, 0);

    // Table of frames.
    for (int v = 0; v < 4; v++) begin
      send_byte(vecs[v].data, vecs[v].stop);
      chk("vec_dr", data_ready, 1);
      chk("vec_rx_data", rx_data, vecs[v].exp_data);
      chk("vec_fe", frame_err, vecs[v].exp_fe);
      lsr_read();
      chk("vec_fe_clr", frame_err, 0);
      pop();
      chk("vec_pop_dr", data_ready, 0);
    end

    // Overrun: five bytes into a four-entry FIFO.
    for (int k = 1; k <= 5; k++) begin
      send_byte(8'(k), 1'b1);
      if (k == 4) chk("ovr_not_yet", overrun_err, 0);
    end
    chk("ovr_set", overrun_err, 1);
    for (int k = 1; k <= 4; k++) begin
      chk("ovr_rx_data", rx_data, 8'(k));
      pop();
    end
    chk("ovr_empty", data_ready, 0);
    lsr_read();
    chk("ovr_clr", overrun_err, 0);

    // Full FIFO with a pop in the push cycle (divisor 1: tick every cycle).
    divisor = 16'd1;
    step(20);
    for (int k = 0; k < 4; k++) send_byte(8'h11 + 8'(k), 1'b1);
    fork
      send_byte(8'h77, 1'b1);
      begin
        step(push_wait);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
      end
    join
    chk("fullpop_no_ovr", overrun_err, 0);
    chk("fullpop_rx0", rx_data, 8'h12);
    pop();
    chk("fullpop_rx1", rx_data, 8'h13);
    pop();
    chk("fullpop_rx2", rx_data, 8'h14);
    pop();
    chk("fullpop_rx3", rx_data, 8'h77);
    pop();
    chk("fullpop_empty", data_ready, 0);

    // Reset during data bit 3 with a byte already buffered.
    divisor = 16'd4;
    step(20);
    send_byte(8'hC3, 1'b1);
    serial_in = 1'b0;
    step(64);
    for (int i = 0; i < 3; i++) begin
      serial_in = i[0];
      step(64);
    end
    serial_in = 1'b1;
    step(32);
    rst_n = 1'b0;
    step(2);
    chk("mid_rst_dr", data_ready, 0);
    chk("mid_rst_rx_data", rx_data, 8'h00);
    chk("mid_rst_ov", overrun_err, 0);
    chk("mid_rst_fe", frame_err, 0);
    chk("mid_rst_irq", irq, 0);
    step(5);
    rst_n = 1'b1;
    step(300);
    chk("post_rst_no_push", data_ready, 0);
    send_byte(8'h5A, 1'b1);
    chk("post_rst_dr", data_ready, 1);
    chk("post_rst_rx_data", rx_data, 8'h5A);
    pop();
    chk("post_rst_empty", data_ready, 0);

`ifdef UART_RX_PARITY_EN
    // Odd number of ones with parity bit 0.
    tx_par_flip = 1'b1;
    send_byte(8'h07, 1'b1);
    tx_par_flip = 1'b0;
    chk("par_err_set", parity_err, 1);
    chk("par_rx_data", rx_data, 8'h07);
    lsr_read();
    chk("par_err_clr", parity_err, 0);
    pop();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
